// File: rtl/kyber_pkg.sv
// kyber_pkg: shared Kyber coefficient-RAM constants, host FSM states and word pack/slot helpers.
package kyber_pkg;
    localparam int KYBER_Q       = 3329;
    localparam int COEF_W        = 12;
    localparam int COEF_PER_WORD = 8;
    localparam int RAM_AW        = 8;
    localparam int RAM_DEPTH     = 1 << RAM_AW;
    localparam int WORD_W        = COEF_W * COEF_PER_WORD;

    typedef enum logic [2:0] {
        IDLE, LD_COLLECT, LD_WRITE, UL_REQ, UL_WAIT, UL_SHIFT, DONE
    } state_e;

    function automatic logic [WORD_W-1:0] put_slot(input logic [WORD_W-1:0] w, input logic [2:0] k,
                                                   input logic [COEF_W-1:0] c);
        put_slot = w;
        put_slot[k*COEF_W +: COEF_W] = c;
    endfunction

    function automatic logic [COEF_W-1:0] get_slot(input logic [WORD_W-1:0] w, input logic [2:0] k);
        return w[k*COEF_W +: COEF_W];
    endfunction
endpackage

// File: rtl/poly_ram_ctrl_if.sv
// poly_ram_ctrl_if: core RAM port, host control and coefficient stream signals of poly_ram_ctrl.
interface poly_ram_ctrl_if;
    import kyber_pkg::*;
    logic              core_lock;
    logic [RAM_AW-1:0] core_raddr;
    logic [WORD_W-1:0] core_rdata;
    logic [RAM_AW-1:0] core_waddr;
    logic [WORD_W-1:0] core_wdata;
    logic              core_wen;
    logic              host_start;
    logic              host_unload;
    logic [RAM_AW-1:0] host_base;
    logic [RAM_AW:0]   host_words;
    logic [COEF_W-1:0] s_coef;
    logic              s_valid;
    logic              s_ready;
    logic [COEF_W-1:0] m_coef;
    logic              m_valid;
    logic              m_ready;
    logic              host_busy;
    logic              host_done;
    logic              range_err;

    modport master (
        output core_lock, core_raddr, core_waddr, core_wdata, core_wen,
               host_start, host_unload, host_base, host_words, s_coef, s_valid, m_ready,
        input  core_rdata, s_ready, m_coef, m_valid, host_busy, host_done, range_err
    );
    modport slave (
        input  core_lock, core_raddr, core_waddr, core_wdata, core_wen,
               host_start, host_unload, host_base, host_words, s_coef, s_valid, m_ready,
        output core_rdata, s_ready, m_coef, m_valid, host_busy, host_done, range_err
    );
endinterface

// File: rtl/poly_ram_bank.sv
// poly_ram_bank: 256x96 1R1W memory with registered, read-before-write output.
module poly_ram_bank
    import kyber_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [RAM_AW-1:0] raddr_i,
    input  logic [RAM_AW-1:0] waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic              wen_i,
    output logic [WORD_W-1:0] rdata_o
);
    logic [WORD_W-1:0] mem_q [RAM_DEPTH];
    logic [WORD_W-1:0] rdata_q;

    // Writes are blocked during reset so an aborted load never lands in memory.
    always_ff @(posedge clk) begin
        if (wen_i && !rst) mem_q[waddr_i] <= wdata_i;
        rdata_q <= rst ? '0 : mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/poly_ram_ctrl.sv
// poly_ram_ctrl: core port mux and host load/unload FSM around a 256x96 coefficient RAM.
// Define POLY_RAM_RANGE_CHECK_EN to reduce loaded coefficients >= Q and flag them on range_err.
module poly_ram_ctrl
    import kyber_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    poly_ram_ctrl_if.slave bus
);
    state_e            state_q, state_d;
    logic [2:0]        k_q, k_d;
    logic [RAM_AW:0]   widx_q, widx_d, words_q, words_d;
    logic [RAM_AW-1:0] base_q, base_d, host_addr;
    logic [WORD_W-1:0] pack_q, pack_d, shift_q, shift_d, rdata;
    logic              rerr_q, rerr_d, s_hs, last_word, coef_oor;
    logic [COEF_W-1:0] coef_in;

`ifdef POLY_RAM_RANGE_CHECK_EN
    assign coef_oor = bus.s_coef >= COEF_W'(KYBER_Q);
    assign coef_in  = coef_oor ? bus.s_coef - COEF_W'(KYBER_Q) : bus.s_coef;
`else
    assign coef_oor = 1'b0;
    assign coef_in  = bus.s_coef;
`endif

    assign host_addr = base_q + widx_q[RAM_AW-1:0];
    assign last_word = (widx_q + 1'b1) == words_q;
    assign s_hs      = bus.s_valid && bus.s_ready;

    poly_ram_bank u_bank (
        .clk     (clk),
        .rst     (rst),
        .raddr_i (bus.core_lock ? bus.core_raddr : host_addr),
        .waddr_i (bus.core_lock ? bus.core_waddr : host_addr),
        .wdata_i (bus.core_lock ? bus.core_wdata : pack_q),
        .wen_i   (bus.core_lock ? bus.core_wen : state_q == LD_WRITE),
        .rdata_o (rdata)
    );

    assign bus.core_rdata = rdata;
    assign bus.s_ready    = state_q == LD_COLLECT && !bus.core_lock;
    assign bus.m_valid    = state_q == UL_SHIFT;
    assign bus.m_coef     = bus.m_valid ? get_slot(shift_q, k_q) : '0;
    assign bus.host_busy  = state_q != IDLE;
    assign bus.host_done  = state_q == DONE;
    assign bus.range_err  = rerr_q;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        widx_d  = widx_q;
        words_d = words_q;
        base_d  = base_q;
        pack_d  = pack_q;
        shift_d = shift_q;
        rerr_d  = rerr_q;
        case (state_q)
            IDLE: if (bus.host_start) begin
                base_d  = bus.host_base;
                words_d = bus.host_words;
                widx_d  = '0;
                k_d     = '0;
                rerr_d  = 1'b0;
                state_d = bus.host_words == '0 ? DONE : bus.host_unload ? UL_REQ : LD_COLLECT;
            end
            LD_COLLECT: if (s_hs) begin
                pack_d  = put_slot(pack_q, k_q, coef_in);
                k_d     = k_q + 3'd1;
                rerr_d  = rerr_q | coef_oor;
                state_d = k_q == 3'd7 ? LD_WRITE : LD_COLLECT;
            end
            LD_WRITE: if (!bus.core_lock) begin
                widx_d  = widx_q + 1'b1;
                state_d = last_word ? DONE : LD_COLLECT;
            end
            UL_REQ: state_d = bus.core_lock ? UL_REQ : UL_WAIT;
            // Read data issued in UL_REQ is on the registered port now, even if the core relocked.
            UL_WAIT: begin
                shift_d = rdata;
                state_d = UL_SHIFT;
            end
            UL_SHIFT: if (bus.m_ready) begin
                k_d = k_q + 3'd1;
                if (k_q == 3'd7) begin
                    widx_d  = widx_q + 1'b1;
                    state_d = last_word ? DONE : UL_REQ;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            widx_q  <= '0;
            words_q <= '0;
            base_q  <= '0;
            pack_q  <= '0;
            shift_q <= '0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            widx_q  <= widx_d;
            words_q <= words_d;
            base_q  <= base_d;
            pack_q  <= pack_d;
            shift_q <= shift_d;
            rerr_q  <= rerr_d;
        end
    end
endmodule

// File: tb/tb_poly_ram_ctrl.sv
// tb_poly_ram_ctrl: randomized scoreboard bench for poly_ram_ctrl against a flat coefficient-array model.
module tb_poly_ram_ctrl;
    import kyber_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    poly_ram_ctrl_if bus();
    poly_ram_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;
    logic [11:0] cm [0:2047];
    logic [95:0] exp_rd [$];
    logic [11:0] exp_m [$];
    logic [11:0] ld_vals [$];
    bit rd_issue = 0;
    bit rd_pend = 0;
    int done_seen = 0;
    int exp_done = 0;
    bit exp_rerr = 0;
    logic pv = 0, pr = 0;
    logic [11:0] pc = '0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected completion", name);
    endtask

    // Scoreboard monitor: pops expectations whenever the DUT presents data.
    always @(negedge clk) begin
        if (rd_pend) begin
            if (exp_rd.size() == 0) fail_now("core_rdata_unexpected");
            else chk("core_rdata", bus.core_rdata, exp_rd.pop_front());
        end
        rd_pend = rd_issue;
        if (pv && !pr) begin
            chk("m_valid_hold", bus.m_valid, 1);
            chk("m_coef_hold", bus.m_coef, pc);
        end
        if (bus.m_valid && bus.m_ready) begin
            if (exp_m.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL m_extra: got %h expected no beat", bus.m_coef);
            end else chk("m_coef", bus.m_coef, exp_m.pop_front());
        end
        pv = bus.m_valid;
        pr = bus.m_ready;
        pc = bus.m_coef;
        if (bus.host_done) done_seen++;
    end

    function automatic logic [11:0] stored(input logic [11:0] c);
`ifdef POLY_RAM_RANGE_CHECK_EN
        return c >= 12'd3329 ? c - 12'd3329 : c;
`else
        return c;
`endif
    endfunction

    function automatic logic [95:0] mword(input int a);
        mword = '0;
        for (int i = 0; i < 8; i++) mword[i*12 +: 12] = cm[a*8 + i];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic core_write(input int a, input logic [95:0] w);
        bus.core_lock = 1;
        bus.core_waddr = a[7:0];
        bus.core_wdata = w;
        bus.core_wen = 1;
        tick();
        bus.core_wen = 0;
        for (int i = 0; i < 8; i++) cm[a*8 + i] = w[i*12 +: 12];
    endtask

    task automatic core_read(input int a);
        bus.core_lock = 1;
        bus.core_raddr = a[7:0];
        rd_issue = 1;
        exp_rd.push_back(mword(a));
        tick();
        rd_issue = 0;
    endtask

    task automatic read_range(input int b, input int n);
        for (int i = 0; i < n; i++) core_read((b + i) % 256);
        tick();
        bus.core_lock = 0;
    endtask

    task automatic start_xfer(input bit u, input int b, input int w);
        bus.core_lock = 0;
        bus.host_start = 1;
        bus.host_unload = u;
        bus.host_base = b[7:0];
        bus.host_words = w[8:0];
        tick();
        bus.host_start = 0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_seen < exp_done && n < 300) begin
            tick();
            n++;
        end
        repeat (3) tick();
        chk("host_done_count", done_seen, exp_done);
        chk("host_busy_idle", bus.host_busy, 0);
    endtask

    task automatic do_load(input int b, input int w, input int lock_at, input bit inj);
        int idx = 0;
        int cyc = 0;
        bit hs;
        bit injd = 0;
        exp_rerr = 0;
        for (int i = 0; i < w*8; i++) begin
            cm[((b + i/8) % 256)*8 + i%8] = stored(ld_vals[i]);
`ifdef POLY_RAM_RANGE_CHECK_EN
            if (ld_vals[i] >= 12'd3329) exp_rerr = 1;
`endif
        end
        start_xfer(0, b, w);
        exp_done++;
        chk("host_busy_load", bus.host_busy, 1);
        while (idx < w*8 && cyc < 4000) begin
            if (idx == lock_at) begin
                bus.s_valid = 1;
                bus.core_lock = 1;
                repeat (10) begin
                    @(negedge clk);
                    chk("s_ready_locked", bus.s_ready, 0);
                    tick();
                end
                bus.core_lock = 0;
                lock_at = -1;
            end
            bus.s_valid = $urandom_range(0, 3) != 0;
            bus.s_coef = ld_vals[idx];
            bus.host_start = inj && !injd && idx == 10;
            if (bus.host_start) begin
                injd = 1;
                bus.host_unload = 1;
                bus.host_base = 8'(b + 100);
                bus.host_words = 9'd1;
            end
            @(negedge clk);
            hs = bus.s_valid && bus.s_ready;
            tick();
            bus.host_start = 0;
            cyc++;
            if (hs) idx++;
        end
        bus.s_valid = 0;
        if (cyc >= 4000) fail_now("load_stream");
        wait_done();
        chk("range_err_load", bus.range_err, exp_rerr);
    endtask

    task automatic do_unload(input int b, input int w);
        int cyc = 0;
        for (int i = 0; i < w*8; i++) exp_m.push_back(cm[((b + i/8) % 256)*8 + i%8]);
        start_xfer(1, b, w);
        exp_done++;
        while (exp_m.size() > 0 && cyc < 4000) begin
            bus.m_ready = $urandom_range(0, 1);
            tick();
            cyc++;
        end
        bus.m_ready = 0;
        if (cyc >= 4000) fail_now("unload_stream");
        wait_done();
    endtask

    task automatic rand_vals(input int n);
        ld_vals.delete();
        for (int i = 0; i < n; i++) ld_vals.push_back(12'($urandom_range(0, 4095)));
    endtask

    initial begin
        logic [95:0] w;
        int b, n, hs_n;
        bus.core_lock = 0; bus.core_raddr = '0; bus.core_waddr = '0; bus.core_wdata = '0;
        bus.core_wen = 0; bus.host_start = 0; bus.host_unload = 0; bus.host_base = '0;
        bus.host_words = '0; bus.s_coef = '0; bus.s_valid = 0; bus.m_ready = 0;
        for (int i = 0; i < 2048; i++) cm[i] = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_core_rdata", bus.core_rdata, 0);
        chk("rst_busy", bus.host_busy, 0);
        chk("rst_done", bus.host_done, 0);
        chk("rst_s_ready", bus.s_ready, 0);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_range_err", bus.range_err, 0);
        rst = 0;
        tick();
        // Give every word a known value so the model is defined everywhere.
        for (int a = 0; a < 256; a++) core_write(a, {$urandom, $urandom, $urandom});

        for (int i = 0; i < 8; i++) w[i*12 +: 12] = 12'(i);
        core_write(5, w);
        read_range(5, 1);
        // Same-address read and write in one cycle returns the old word.
        bus.core_lock = 1;
        bus.core_raddr = 8'd5;
        rd_issue = 1;
        exp_rd.push_back(mword(5));
        w = {$urandom, $urandom, $urandom};
        core_write(5, w);
        rd_issue = 0;
        read_range(5, 1);

        ld_vals.delete();
        for (int i = 0; i < 64; i++) ld_vals.push_back(12'(i));
        do_load(250, 8, -1, 0);
        read_range(250, 8);
        do_unload(250, 2);
        do_unload(0, 2);

        rand_vals(48);
        do_load(100, 6, 20, 1);
        read_range(100, 6);
        read_range(200, 1);
        do_unload(100, 6);

        start_xfer(0, 7, 0);
        exp_done++;
        @(negedge clk);
        chk("zero_done_pulse", bus.host_done, 1);
        tick();
        @(negedge clk);
        chk("zero_done_low", bus.host_done, 0);
        wait_done();
        read_range(7, 1);

        // Reset after 12 handshakes: only the first full word reaches memory.
        rand_vals(12);
        for (int i = 0; i < 8; i++) cm[60*8 + i] = stored(ld_vals[i]);
        start_xfer(0, 60, 2);
        hs_n = 0;
        n = 0;
        while (hs_n < 12 && n < 500) begin
            bus.s_valid = 1;
            bus.s_coef = ld_vals[hs_n];
            @(negedge clk);
            if (bus.s_ready) hs_n++;
            tick();
            n++;
        end
        bus.s_valid = 0;
        if (n >= 500) fail_now("partial_stream");
        rst = 1;
        tick();
        @(negedge clk);
        chk("midrst_busy", bus.host_busy, 0);
        chk("midrst_s_ready", bus.s_ready, 0);
        chk("midrst_m_valid", bus.m_valid, 0);
        chk("midrst_m_coef", bus.m_coef, 0);
        chk("midrst_done", bus.host_done, 0);
        chk("midrst_range_err", bus.range_err, 0);
        chk("midrst_core_rdata", bus.core_rdata, 0);
        rst = 0;
        tick();
        wait_done();
        read_range(60, 2);

        for (int t = 0; t < 4; t++) begin
            b = $urandom_range(0, 255);
            n = $urandom_range(1, 5);
            rand_vals(n*8);
            do_load(b, n, -1, 0);
            do_unload(b, n);
            read_range(b, n);
        end

`ifdef POLY_RAM_RANGE_CHECK_EN
        rand_vals(8);
        ld_vals[0] = 12'd3330;
        do_load(30, 1, -1, 0);
        chk("range_err_set", bus.range_err, 1);
        read_range(30, 1);
        start_xfer(1, 30, 1);
        chk("range_err_cleared", bus.range_err, 0);
        for (int i = 0; i < 8; i++) exp_m.push_back(cm[30*8 + i]);
        exp_done++;
        n = 0;
        while (exp_m.size() > 0 && n < 500) begin
            bus.m_ready = 1;
            tick();
            n++;
        end
        bus.m_ready = 0;
        if (n >= 500) fail_now("range_unload");
        wait_done();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
